led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 25_000_000, base tick period in CLOCK_50 cycles; legal range 8..2^26-1.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all logic on rising edge; no derived clocks.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port run  input  1  level; 1 = sequence advances on ticks, 0 = pause.
REQ-005 SHALL have port step  input  1  single-cycle pulse; advances pattern once while paused.
REQ-006 SHALL have port clear  input  1  single-cycle pulse; returns block to IDLE.
REQ-007 SHALL have port mode  input  2  pattern select: 00 alternate, 01 walk, 10 ping-pong, 11 binary count.
REQ-008 SHALL have port speed  input  2  tick period = TICK_DIV >> speed.
REQ-009 SHALL have port LED  output  8  registered pattern output.
REQ-010 SHALL have port tick  output  1  registered one-cycle pulse marking each period end.
REQ-011 SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.

Function
REQ-012 SHALL keep a 26-bit counter cnt and assert tick in the cycle cnt == (TICK_DIV>>speed)-1; cnt then wraps to 0.
REQ-013 SHALL, on a speed change, restart counting only at wrap; if cnt >= new period-1, tick SHALL assert the next cycle, then cnt wraps.
REQ-014 SHALL count cnt only in RUN; in IDLE cnt = 0; in PAUSE cnt holds.
REQ-015 SHALL leave IDLE for RUN on the first cycle with run=1; that edge loads LED with the current mode's seed and clears cnt.
REQ-016 SHALL define seeds: alternate 0x55; walk 0x01; ping-pong 0x01 with direction = left; count 0x00.
REQ-017 SHALL advance LED at the clock edge ending a tick cycle; the new value is visible the cycle after tick=1.
REQ-018 SHALL advance alternate as 0x55<->0xAA; any other LED value loads 0x55.
REQ-019 SHALL advance walk by rotating left one bit, with 0x80 -> 0x01.
REQ-020 SHALL advance ping-pong by shifting one bit in the current direction; at 0x80 it reverses to right (next 0x40); at 0x01 going right it reverses to left (next 0x02).
REQ-021 SHALL advance count as LED+1 modulo 256, so 0xFF -> 0x00.
REQ-022 SHALL compare mode with the last-applied mode at every advance; on mismatch it loads the new mode's seed instead of advancing and records the new mode.
REQ-023 SHALL go RUN -> PAUSE when run=0 and PAUSE -> RUN when run=1; LED holds across both transitions and cnt resumes from its held value.
REQ-024 SHALL, in PAUSE, perform exactly one advance per step pulse, with tick kept low; step in IDLE or RUN is ignored.
REQ-025 SHALL, on clear in any state, go to IDLE with LED=0x00, cnt=0 and tick=0 on the next edge.
REQ-026 SHALL give priority clear > run/state transition > step for events in the same cycle.
REQ-027 SHALL, when a tick and a run falling edge coincide in RUN, perform that tick's advance and then enter PAUSE.

Reset
REQ-028 SHALL, with RESET=1 at an edge, set state=IDLE, LED=0x00, tick=0, cnt=0, direction=left and last-applied mode=00, overriding all other inputs.
REQ-029 SHALL, on RESET mid-sequence, discard sequence state; it resumes only via IDLE->RUN with a fresh seed.

Verification
REQ-030 SHALL cover: TICK_DIV=8, speed=0, mode=00, run=1 after reset -> LED 0x55, then 0xAA after 8 cycles, then 0x55; tick period 8.
REQ-031 SHALL cover: mode=10, run held -> LED 01,02,04,...,80,40,...,01,02 across 16 ticks.
REQ-032 SHALL cover: mode=11 from 0xFE -> 0xFF -> 0x00 wrap; speed=2 with TICK_DIV=8 -> tick every 2 cycles.
REQ-033 SHALL cover: run=0 mid-period, 3 step pulses -> exactly 3 advances, tick=0; run=1 -> next tick after the remaining held cnt cycles.
REQ-034 SHALL cover: clear, step and run=1 in the same cycle from PAUSE -> state=IDLE, LED=0x00; run=1 next cycle -> RUN with seed.
REQ-035 SHALL cover: mode change 01->00 while walking at 0x04 -> next tick loads 0x55, not 0x08; RESET mid-RUN -> LED 0x00, state 00 next cycle.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps one of four 8-bit patterns on a programmable tick,
// with run/pause, single-step and clear control.
`timescale 1ns/1ps

module led_seq_ctrl #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       run,
  input  logic       step,
  input  logic       clear,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [7:0] LED,
  output logic       tick,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [25:0] DIV = 26'(TICK_DIV);

  state_t      cur_state, nxt_state;
  logic [25:0] cnt, cnt_nxt;
  logic [25:0] period_m1;
  logic [7:0]  led_nxt, adv_led;
  logic        tick_nxt;
  logic        dir_right, dir_nxt, adv_dir;
  logic [1:0]  last_mode, last_mode_nxt;
  logic        do_advance;

  assign period_m1 = (DIV >> speed) - 26'd1;
  assign state     = cur_state;

  function automatic logic [7:0] seed_of(input logic [1:0] m);
    case (m)
      2'b00:   seed_of = 8'h55;
      2'b01:   seed_of = 8'h01;
      2'b10:   seed_of = 8'h01;
      default: seed_of = 8'h00;
    endcase
  endfunction

  // One pattern advance; a mode change since the last advance reseeds instead.
  always_comb begin
    adv_led = LED;
    adv_dir = dir_right;
    if (mode != last_mode) begin
      adv_led = seed_of(mode);
      adv_dir = 1'b0;
    end else begin
      case (mode)
        2'b00: adv_led = (LED == 8'h55) ? 8'hAA : 8'h55;
        2'b01: adv_led = {LED[6:0], LED[7]};
        2'b10: begin
          if (!dir_right) begin
            if (LED == 8'h80) begin
              adv_led = 8'h40;
              adv_dir = 1'b1;
            end else begin
              adv_led = {LED[6:0], 1'b0};
            end
          end else begin
            if (LED == 8'h01) begin
              adv_led = 8'h02;
              adv_dir = 1'b0;
            end else begin
              adv_led = {1'b0, LED[7:1]};
            end
          end
        end
        default: adv_led = LED + 8'd1;
      endcase
    end
  end

  // Tick is registered, so it is computed from next-cycle cnt; cnt wraps on the edge after tick.
  always_comb begin
    nxt_state     = cur_state;
    cnt_nxt       = cnt;
    led_nxt       = LED;
    dir_nxt       = dir_right;
    last_mode_nxt = last_mode;
    do_advance    = 1'b0;
    if (clear) begin
      nxt_state = IDLE;
      cnt_nxt   = '0;
      led_nxt   = 8'h00;
    end else begin
      case (cur_state)
        IDLE: begin
          cnt_nxt = '0;
          if (run) begin
            nxt_state     = RUN;
            led_nxt       = seed_of(mode);
            dir_nxt       = 1'b0;
            last_mode_nxt = mode;
          end
        end
        RUN: begin
          cnt_nxt    = tick ? 26'd0 : cnt + 26'd1;
          do_advance = tick;
          if (!run) nxt_state = PAUSE;
        end
        PAUSE: begin
          if (run)       nxt_state  = RUN;
          else if (step) do_advance = 1'b1;
        end
        default: begin
          nxt_state = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
    if (do_advance) begin
      led_nxt       = adv_led;
      dir_nxt       = adv_dir;
      last_mode_nxt = mode;
    end
    tick_nxt = (nxt_state == RUN) && (cnt_nxt >= period_m1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cur_state <= IDLE;
      cnt       <= '0;
      LED       <= 8'h00;
      tick      <= 1'b0;
      dir_right <= 1'b0;
      last_mode <= 2'b00;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      LED       <= led_nxt;
      tick      <= tick_nxt;
      dir_right <= dir_nxt;
      last_mode <= last_mode_nxt;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=8; expected values are hand-computed.
`timescale 1ns/1ps

module tb_led_seq_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic       run      = 1'b0;
  logic       step     = 1'b0;
  logic       clear    = 1'b0;
  logic [1:0] mode     = 2'b00;
  logic [1:0] speed    = 2'b00;
  logic [7:0] LED;
  logic       tick;
  logic [1:0] state;

  int n_compared   = 0;
  int n_mismatched = 0;

  led_seq_ctrl #(.TICK_DIV(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .run      (run),
    .step     (step),
    .clear    (clear),
    .mode     (mode),
    .speed    (speed),
    .LED      (LED),
    .tick     (tick),
    .state    (state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic c,
                                input logic [1:0] m, input logic [1:0] sp);
    run   = r;
    step  = s;
    clear = c;
    mode  = m;
    speed = sp;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] pp_exp [16];

  initial begin
    pp_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    // Reset state
    wait_cycles(2);
    RESET = 1'b0;
    check_output("rst_state", 8'(state), 8'h00);
    check_output("rst_led", LED, 8'h00);
    check_output("rst_tick", 8'(tick), 8'h00);

    // Alternate pattern, period 8
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    wait_cycles(1);
    check_output("alt_state", 8'(state), 8'h01);
    check_output("alt_seed", LED, 8'h55);
    wait_cycles(6);
    check_output("alt_pre_tick", 8'(tick), 8'h00);
    wait_cycles(1);
    check_output("alt_tick1", 8'(tick), 8'h01);
    check_output("alt_led_at_tick", LED, 8'h55);
    wait_cycles(1);
    check_output("alt_aa", LED, 8'hAA);
    check_output("alt_tick_low", 8'(tick), 8'h00);
    wait_cycles(7);
    check_output("alt_tick2", 8'(tick), 8'h01);
    wait_cycles(1);
    check_output("alt_55", LED, 8'h55);

    // Walk with mode change to alternate at 0x04
    apply_stimulus(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    wait_cycles(1);
    check_output("clr_state", 8'(state), 8'h00);
    check_output("clr_led", LED, 8'h00);
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    wait_cycles(1);
    check_output("walk_seed", LED, 8'h01);
    wait_cycles(8);
    check_output("walk_02", LED, 8'h02);
    wait_cycles(8);
    check_output("walk_04", LED, 8'h04);
    mode = 2'b00;
    wait_cycles(8);
    check_output("walk_reseed", LED, 8'h55);

    // Reset in the middle of RUN
    RESET = 1'b1;
    run   = 1'b0;
    wait_cycles(1);
    check_output("midrst_led", LED, 8'h00);
    check_output("midrst_state", 8'(state), 8'h00);
    check_output("midrst_tick", 8'(tick), 8'h00);
    RESET = 1'b0;

    // Ping-pong over 16 ticks
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b10, 2'b00);
    wait_cycles(1);
    check_output("pp_seed", LED, 8'h01);
    for (int i = 0; i < 16; i++) begin
      wait_cycles(8);
      check_output($sformatf("pp_%0d", i), LED, pp_exp[i]);
    end

    // Binary count at speed 2 (period 2), wrap at 0xFF
    apply_stimulus(1'b1, 1'b0, 1'b1, 2'b10, 2'b00);
    wait_cycles(1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b10);
    wait_cycles(1);
    check_output("cnt_seed", LED, 8'h00);
    wait_cycles(1);
    check_output("cnt_tick_hi", 8'(tick), 8'h01);
    wait_cycles(1);
    check_output("cnt_tick_lo", 8'(tick), 8'h00);
    check_output("cnt_01", LED, 8'h01);
    wait_cycles(506);
    check_output("cnt_fe", LED, 8'hFE);
    wait_cycles(2);
    check_output("cnt_ff", LED, 8'hFF);
    wait_cycles(2);
    check_output("cnt_wrap", LED, 8'h00);

    // Pause mid-period, three steps, then resume from the held count
    apply_stimulus(1'b1, 1'b0, 1'b1, 2'b11, 2'b10);
    wait_cycles(1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    wait_cycles(1);
    check_output("pz_seed", LED, 8'h55);
    wait_cycles(3);
    run = 1'b0;
    wait_cycles(1);
    check_output("pz_state", 8'(state), 8'h02);
    step = 1'b1;
    wait_cycles(1);
    step = 1'b0;
    check_output("pz_step1", LED, 8'hAA);
    check_output("pz_step1_tick", 8'(tick), 8'h00);
    wait_cycles(1);
    step = 1'b1;
    wait_cycles(1);
    step = 1'b0;
    check_output("pz_step2", LED, 8'h55);
    wait_cycles(1);
    step = 1'b1;
    wait_cycles(1);
    step = 1'b0;
    check_output("pz_step3", LED, 8'hAA);
    check_output("pz_step3_tick", 8'(tick), 8'h00);
    wait_cycles(4);
    check_output("pz_hold", LED, 8'hAA);
    run = 1'b1;
    wait_cycles(1);
    check_output("pz_resume_state", 8'(state), 8'h01);
    wait_cycles(2);
    check_output("pz_resume_notick", 8'(tick), 8'h00);
    wait_cycles(1);
    check_output("pz_resume_tick", 8'(tick), 8'h01);
    wait_cycles(1);
    check_output("pz_resume_adv", LED, 8'h55);

    // Clear, step and run together from PAUSE
    run = 1'b0;
    wait_cycles(1);
    check_output("prio_pause", 8'(state), 8'h02);
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    wait_cycles(1);
    check_output("prio_state", 8'(state), 8'h00);
    check_output("prio_led", LED, 8'h00);
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    wait_cycles(1);
    check_output("prio_run_state", 8'(state), 8'h01);
    check_output("prio_run_seed", LED, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
